mem_arbiter: RTL

Shares the single off-chip memory port between the instruction-cache and data-cache miss/write-back interfaces. The block sits between the two caches and the memory model, below the `RISCV_Pipeline` core. It serialises their block transfers with round-robin arbitration and holds each granted transaction stable until memory acknowledges it. The single winner's command is registered; the response is routed back to the owner only.

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one off-chip memory port between the I-cache and D-cache block
// transfer interfaces. A round-robin arbiter picks one requester in IDLE,
// latches its command into the mem_* registers and holds it unchanged until
// memory answers with mem_ready. The completion pulse is routed only to the
// owner of the transaction. A one-cycle DONE state follows every transfer so
// the served cache can drop its request before arbitration resumes.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   i_read/i_write/i_addr/
//   i_wdata                    I-cache request (held until i_ready)
//   i_rdata, i_ready           I-cache read line and completion pulse
//   d_*                        same set for the D-cache
//   mem_read/mem_write/
//   mem_addr/mem_wdata         registered memory command
//   mem_rdata, mem_ready       memory read line and completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Owner encoding: 0 = I-cache, 1 = D-cache.
    state_t              r_state;
    state_t              w_state_next;
    logic                r_owner;
    logic                r_last;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_req_i;
    logic                w_req_d;
    logic                w_grant;
    logic                w_grant_owner;
    logic                w_complete;
    logic                w_sel_read;
    logic                w_sel_write;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    // Opcode of whichever side is being granted this cycle.
    assign w_sel_read  = w_grant_owner ? d_read  : i_read;
    assign w_sel_write = w_grant_owner ? d_write : i_write;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and arbitration decision
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        w_state_next  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = 1'b0;
        w_complete    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req_i || w_req_d) begin
                    w_grant      = 1'b1;
                    w_state_next = BUSY;
                    // On a tie the side that was not served last wins; this
                    // gives strict I/D alternation under continuous load.
                    if (w_req_i && w_req_d) begin
                        w_grant_owner = ~r_last;
                    end else begin
                        w_grant_owner = w_req_d;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command / ownership registers
    // -------------------------------------------------------------------------
    // Address and write data are loaded only on grant, so they stay frozen for
    // the whole BUSY period no matter what the caches drive meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant) begin
            r_owner     <= w_grant_owner;
            // A requester asserting both read and write is treated as a write.
            r_mem_write <= w_sel_write;
            r_mem_read  <= w_sel_read & ~w_sel_write;
            r_mem_addr  <= w_grant_owner ? d_addr  : i_addr;
            r_mem_wdata <= w_grant_owner ? d_wdata : i_wdata;
        end else if (w_complete) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_last      <= r_owner;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // mem_ready outside BUSY is ignored and never produces a ready pulse.
    assign i_ready = (r_state == BUSY) & mem_ready & ~r_owner;
    assign d_ready = (r_state == BUSY) & mem_ready &  r_owner;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
